ff_exciter: RTL

FF_EXCITER -- requirements
Module: ff_exciter

---
 rtl/ff_exc_pkg.sv | 26 ++
 rtl/ff_exc_encode.sv | 34 +++
 rtl/ff_exciter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ff_exc_pkg.sv
// Shared definitions for the flip-flop exciter.
// Holds the FSM state encoding, the bit positions of the per-flip-flop
// mismatch flags, the mismatch counter width and a saturating-increment helper.
package ff_exc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StCheck
    } state_e;

    // err bit positions: {jk, sr, d, t}
    localparam int unsigned ErrW  = 4;
    localparam int unsigned ErrJk = 3;
    localparam int unsigned ErrSr = 2;
    localparam int unsigned ErrD  = 1;
    localparam int unsigned ErrT  = 0;

    localparam int unsigned CntW = 8;
    localparam logic [CntW-1:0] CntMax = '1;

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (v == CntMax) ? v : v + {{(CntW-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ff_exc_encode.sv
// Combinational excitation table for JK, SR, D and T flip-flops.
// Ports:
//   q_jk, q_sr, q_d, q_t : current state of each driven flip-flop
//   tgt                  : desired next state
//   j, k, s, r, d, t     : excitation needed to reach tgt from each own q
// SR never produces s=r=1: a set is only requested from 0, a reset only from 1.
module ff_exc_encode (
    input  logic q_jk,
    input  logic q_sr,
    input  logic q_d,
    input  logic q_t,
    input  logic tgt,
    output logic j,
    output logic k,
    output logic s,
    output logic r,
    output logic d,
    output logic t
);

    // q_d is irrelevant to a D flip-flop's excitation; kept for a uniform interface.
    logic unused_q_d;
    assign unused_q_d = q_d;

    always_comb begin
        j = ~q_jk & tgt;
        k = q_jk & ~tgt;
        s = ~q_sr & tgt;
        r = q_sr & ~tgt;
        d = tgt;
        t = q_t ^ tgt;
    end

endmodule

// File: rtl/ff_exciter.sv
// Flip-flop exciter: accepts a target next state, drives the excitation that
// moves external JK/SR/D/T flip-flops to it, then checks their feedback.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   tgt_valid/tgt_ready : target handshake, one target per three cycles
//   tgt                 : desired next state for all four flip-flops
//   q_jk,q_sr,q_d,q_t   : flip-flop feedback
//   j,k,s,r,d,t         : registered excitation outputs
//   done, err           : one-cycle completion pulse, per-FF mismatch {jk,sr,d,t}
//   clr_cnt, mis_cnt    : synchronous clear, saturating count of failed checks
module ff_exciter
    import ff_exc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            tgt_valid,
    input  logic            tgt,
    output logic            tgt_ready,
    input  logic            q_jk,
    input  logic            q_sr,
    input  logic            q_d,
    input  logic            q_t,
    output logic            j,
    output logic            k,
    output logic            s,
    output logic            r,
    output logic            d,
    output logic            t,
    output logic            done,
    output logic [ErrW-1:0] err,
    input  logic            clr_cnt,
    output logic [CntW-1:0] mis_cnt
);

    state_e          state;
    logic            tgt_lat;
    logic            j_n, k_n, s_n, r_n, d_n, t_n;
    logic [ErrW-1:0] err_n;

    ff_exc_encode u_encode (
        .q_jk (q_jk),
        .q_sr (q_sr),
        .q_d  (q_d),
        .q_t  (q_t),
        .tgt  (tgt),
        .j    (j_n),
        .k    (k_n),
        .s    (s_n),
        .r    (r_n),
        .d    (d_n),
        .t    (t_n)
    );

    always_comb begin
        err_n        = '0;
        err_n[ErrJk] = (q_jk != tgt_lat);
        err_n[ErrSr] = (q_sr != tgt_lat);
        err_n[ErrD]  = (q_d != tgt_lat);
        err_n[ErrT]  = (q_t != tgt_lat);
    end

    assign tgt_ready = (state == StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            tgt_lat <= 1'b0;
            j       <= 1'b0;
            k       <= 1'b0;
            s       <= 1'b0;
            r       <= 1'b0;
            d       <= 1'b0;
            t       <= 1'b0;
            done    <= 1'b0;
            err     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (tgt_valid) begin
                        j       <= j_n;
                        k       <= k_n;
                        s       <= s_n;
                        r       <= r_n;
                        d       <= d_n;
                        t       <= t_n;
                        tgt_lat <= tgt;
                        state   <= StDrive;
                    end
                end
                StDrive: begin
                    // Return to hold excitation; d keeps the target so the D FF stays put.
                    j     <= 1'b0;
                    k     <= 1'b0;
                    s     <= 1'b0;
                    r     <= 1'b0;
                    t     <= 1'b0;
                    state <= StCheck;
                end
                StCheck: begin
                    err   <= err_n;
                    done  <= 1'b1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Counts on the same edge that raises done, so mis_cnt is current while done is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_cnt <= '0;
        end else if (clr_cnt) begin
            mis_cnt <= '0;
        end else if (state == StCheck && err_n != '0) begin
            mis_cnt <= sat_inc(mis_cnt);
        end
    end

endmodule
